// File: rtl/amp_pkg.sv
// Shared constants and the amplitude-to-duty conversion used by the PWM stage.
package amp_pkg;

  localparam int AMP_MAX_DEF = 20;
  localparam int GAIN_DEF    = 5;
  localparam int PERIOD_DEF  = 100;
  localparam int DEAD_DEF    = 3;
  localparam int DCNT_W      = 8;

  // Dead-time interlock state, kept as one packed register so it can be probed.
  typedef struct packed {
    logic              tgt;
    logic [DCNT_W-1:0] dcnt;
  } dt_state_t;

  // Signed clamp to [0, amp_max], then unsigned multiply by gain.
  function automatic logic [31:0] clamp_scale(input logic signed [63:0] x,
                                              input int amp_max,
                                              input int gain);
    logic signed [63:0] lim;
    logic [31:0]        c;
    lim = 64'(amp_max);
    if (x < 0) begin
      c = '0;
    end else if (x > lim) begin
      c = 32'(amp_max);
    end else begin
      c = x[31:0];
    end
    return c * 32'(gain);
  endfunction

endpackage

// File: rtl/pwm_deadtime_modulator_deadtime_gen.sv
// Dead-time interlock for one bridge leg: any raw edge forces both gates off
// for DEAD+1 clocks before the new side is enabled.
module deadtime_gen
  import amp_pkg::*;
#(
  parameter int DEAD = DEAD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  if (DEAD < 0 || DEAD >= (1 << DCNT_W)) begin : g_bad_dead
    $error("deadtime_gen: DEAD out of range");
  end

  dt_state_t state_q, state_d;
  logic      hi_q, hi_d;
  logic      lo_q, lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q.tgt  <= 1'b0;
      state_q.dcnt <= DCNT_W'(DEAD);
      hi_q         <= 1'b0;
      lo_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A raw change while counting restarts the gap, so short pulses are swallowed.
  always_comb begin
    state_d = state_q;
    hi_d    = 1'b0;
    lo_d    = 1'b0;
    if (raw != state_q.tgt) begin
      state_d.tgt  = raw;
      state_d.dcnt = DCNT_W'(DEAD);
    end else if (state_q.dcnt != '0) begin
      state_d.dcnt = state_q.dcnt - 1'b1;
    end else begin
      hi_d = state_q.tgt;
      lo_d = ~state_q.tgt;
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;

endmodule

// File: rtl/pwm_deadtime_modulator.sv
// Edge-aligned fixed-frequency PWM with per-period amplitude sampling and a
// dead-time interlock driving complementary high/low gate enables.
module pwm_deadtime_modulator
  import amp_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int AMP_MAX = AMP_MAX_DEF,
  parameter int GAIN    = GAIN_DEF,
  parameter int PERIOD  = PERIOD_DEF,
  parameter int DEAD    = DEAD_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [IN_W-1:0]            expect_signal,
  output logic                              pwm_hi,
  output logic                              pwm_lo,
  output logic                              period_start,
  output logic [$clog2(PERIOD+1)-1:0]       duty_q
);

  localparam int DW = $clog2(PERIOD + 1);

  if (AMP_MAX * GAIN > PERIOD) begin : g_bad_gain
    $error("pwm_deadtime_modulator: AMP_MAX*GAIN exceeds PERIOD");
  end

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_d;
  logic          period_start_q, period_start_d;
  logic          last_cnt;
  logic          raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
    end
  end

  // Duty is only reloaded on the wrap edge so a period never sees two duties.
  always_comb begin
    last_cnt       = (cnt_q == DW'(PERIOD - 1));
    cnt_d          = last_cnt ? '0 : cnt_q + 1'b1;
    period_start_d = (cnt_d == '0);
    duty_d         = duty_q;
    if (last_cnt) begin
      duty_d = DW'(clamp_scale(64'(expect_signal), AMP_MAX, GAIN));
    end
  end

  assign raw          = (cnt_q < duty_q);
  assign period_start = period_start_q;

  deadtime_gen #(
    .DEAD (DEAD)
  ) u_deadtime (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (raw),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Directed bench: startup, table of steady-state amplitudes, mid-period
// sample change, short-pulse suppression (GAIN=1) and asynchronous reset.
module tb_pwm_deadtime_modulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] expect_signal = '0;
  logic signed [31:0] expect_signal2 = 32'sd3;
  logic               pwm_hi, pwm_lo, period_start;
  logic [6:0]         duty_q;
  logic               pwm_hi2, pwm_lo2, period_start2;
  logic [6:0]         duty_q2;

  int checks = 0;
  int fails = 0;
  int overlap = 0;
  int hi2_cnt, lo2_low_cnt;

  typedef struct {
    logic signed [31:0] amp;
    int                 duty;
    int                 hi_cnt;
    int                 lo_cnt;
  } vec_t;

  vec_t vecs[10];

  pwm_deadtime_modulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .expect_signal (expect_signal),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo),
    .period_start  (period_start),
    .duty_q        (duty_q)
  );

  pwm_deadtime_modulator #(.GAIN(1)) dut_g1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .expect_signal (expect_signal2),
    .pwm_hi        (pwm_hi2),
    .pwm_lo        (pwm_lo2),
    .period_start  (period_start2),
    .duty_q        (duty_q2)
  );

  // clock
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((pwm_hi & pwm_lo) | (pwm_hi2 & pwm_lo2)) overlap++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    tick();
    while (!period_start && n < 200) begin
      tick();
      n++;
    end
    if (!period_start) begin
      checks++;
      fails++;
      $display("FAIL period_start_timeout: got no pulse, expected one within 200 clocks");
    end
  endtask

  task automatic measure(output int hi_c, output int lo_c, output int ps_c);
    hi_c = 0; lo_c = 0; ps_c = 0;
    hi2_cnt = 0; lo2_low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwm_hi) hi_c++;
      if (pwm_lo) lo_c++;
      if (period_start) ps_c++;
      if (pwm_hi2) hi2_cnt++;
      if (!pwm_lo2) lo2_low_cnt++;
      tick();
    end
  endtask

  task automatic startup_checks();
    int n;
    expect_signal = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_hi", int'(pwm_hi), 0);
    check("rst_lo", int'(pwm_lo), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty", int'(duty_q), 0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("startup_lo_gap", int'(pwm_lo), 0);
    end
    tick();
    check("startup_lo_on", int'(pwm_lo), 1);
    check("startup_hi_off", int'(pwm_hi), 0);
    n = 4;
    while (!period_start && n < 200) begin
      tick();
      n++;
    end
    check("first_period_start_edge", n, 100);
  endtask

  initial begin
    int hi_c, lo_c, ps_c;

    vecs[0] = '{32'sd10,          50, 46,  46};
    vecs[1] = '{32'sd25,         100, 100, 0};
    vecs[2] = '{-32'sd3,           0, 0,   100};
    vecs[3] = '{32'sd1,            5, 1,   91};
    vecs[4] = '{32'sd20,         100, 100, 0};
    vecs[5] = '{32'sh7fffffff,   100, 100, 0};
    vecs[6] = '{32'sh80000000,     0, 0,   100};
    vecs[7] = '{32'sd4,           20, 16,  76};
    vecs[8] = '{32'sd21,         100, 100, 0};
    vecs[9] = '{32'sd10,          50, 46,  46};

    repeat (3) @(posedge clk);
    startup_checks();

    foreach (vecs[k]) begin
      expect_signal = vecs[k].amp;
      wait_ps();
      check("duty_at_boundary", int'(duty_q), vecs[k].duty);
      wait_ps();
      measure(hi_c, lo_c, ps_c);
      check("steady_hi_clocks", hi_c, vecs[k].hi_cnt);
      check("steady_lo_clocks", lo_c, vecs[k].lo_cnt);
      check("period_start_per_period", ps_c, 1);
    end

    check("g1_hi_never", hi2_cnt, 0);
    check("g1_lo_low_clocks", lo2_low_cnt, 7);

    // Mid-period amplitude change: now at cnt==0 with duty 50.
    repeat (37) tick();
    expect_signal = 32'sd4;
    repeat (62) tick();
    check("mid_change_duty_held", int'(duty_q), 50);
    tick();
    check("mid_change_duty_new", int'(duty_q), 20);
    check("mid_change_period_start", int'(period_start), 1);

    // Asynchronous reset while the high side is on.
    expect_signal = 32'sd25;
    wait_ps();
    wait_ps();
    repeat (20) tick();
    check("pre_reset_hi", int'(pwm_hi), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", int'(pwm_hi), 0);
    check("async_rst_lo", int'(pwm_lo), 0);
    check("async_rst_duty", int'(duty_q), 0);
    check("async_rst_period_start", int'(period_start), 0);
    repeat (2) @(posedge clk);
    startup_checks();

    check("never_both_on", overlap, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
